// File: rtl/cpu_req_arbiter.sv
// Round-robin arbiter that shares one cpu datapath between NUM_REQ requesters, one operation in flight.
// Latency: grant in cycle T, rsp_valid first high in T+1+CPU_LAT; next grant the cycle after the rsp handshake.
// Backpressure: rsp_ready low holds RESP with rsp_id/rsp_data stable; req_ready stays low until IDLE.
module cpu_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int CPU_LAT = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   input  logic [NUM_REQ-1:0]          req_op,
   output logic [DATA_W-1:0]           cpu_a,
   output logic [DATA_W-1:0]           cpu_b,
   output logic                        cpu_op,
   input  logic [DATA_W-1:0]           cpu_result,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (CPU_LAT > 1) ? $clog2(CPU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPU_LAT - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [CNT_W-1:0]   cnt;

   logic               found;
   logic [ID_W-1:0]    winner;
   int                 idx;
   logic [DATA_W-1:0]  sel_a;
   logic [DATA_W-1:0]  sel_b;
   logic               sel_op;

   // Search starts at rr_ptr and wraps; the first valid requester found wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   always_comb begin
      sel_a  = req_a[winner*DATA_W +: DATA_W];
      sel_b  = req_b[winner*DATA_W +: DATA_W];
      sel_op = req_op[winner];
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found && !reset)
         req_ready = NUM_REQ'(1) << winner;
   end

   // Operands are held after the grant, so the cpu result stays stable through RESP.
   assign rsp_data = cpu_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         cpu_a     <= '0;
         cpu_b     <= '0;
         cpu_op    <= 1'b0;
         rsp_id    <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cpu_a  <= sel_a;
                  cpu_b  <= sel_b;
                  cpu_op <= sel_op;
                  rsp_id <= winner;
                  rr_ptr <= (winner == ID_LAST) ? '0 : winner + 1'b1;
                  cnt    <= '0;
                  state  <= EXEC;
                  busy   <= 1'b1;
               end
            end
            EXEC: begin
               if (cnt == CNT_LAST) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_req_arbiter.sv
// Directed bench for cpu_req_arbiter: CPU_LAT=1 instance for most scenarios, CPU_LAT=3 instance for latency.
module tb_cpu_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_op;
   logic        rsp_ready;

   logic [3:0]  req_ready,  req_ready3;
   logic [7:0]  cpu_a,      cpu_a3;
   logic [7:0]  cpu_b,      cpu_b3;
   logic        cpu_op,     cpu_op3;
   logic [7:0]  cpu_result, cpu_result3;
   logic        rsp_valid,  rsp_valid3;
   logic [1:0]  rsp_id,     rsp_id3;
   logic [7:0]  rsp_data,   rsp_data3;
   logic        busy,       busy3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_req_arbiter #(.NUM_REQ(4), .DATA_W(8), .CPU_LAT(1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .cpu_a(cpu_a), .cpu_b(cpu_b), .cpu_op(cpu_op), .cpu_result(cpu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   cpu_req_arbiter #(.NUM_REQ(4), .DATA_W(8), .CPU_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .cpu_a(cpu_a3), .cpu_b(cpu_b3), .cpu_op(cpu_op3), .cpu_result(cpu_result3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3),
      .rsp_data(rsp_data3), .busy(busy3)
   );

   // Cpu datapath models: op 0 = add, op 1 = subtract, registered result.
   logic [7:0] res1;
   logic [7:0] p3 [3];
   always @(posedge clk) begin
      res1  <= cpu_op ? cpu_a - cpu_b : cpu_a + cpu_b;
      p3[0] <= cpu_op3 ? cpu_a3 - cpu_b3 : cpu_a3 + cpu_b3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign cpu_result  = res1;
   assign cpu_result3 = p3[2];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_op = '0;
      tick; tick;
      req_valid = 4'hF; #1;
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if ({cpu_a, cpu_b, cpu_op} !== 17'h0) begin errors++; $display("FAIL reset_cpu_regs: got %h/%h/%b want 0/0/0", cpu_a, cpu_b, cpu_op); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
      req_valid = 4'h0;
      reset = 1'b0;
   endtask

   task automatic test_single;
      req_a[7:0] = 8'd10; req_b[7:0] = 8'd20; req_op[0] = 1'b0;
      req_valid = 4'b0001; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      tick;
      req_valid = 4'b0000; #1;
      checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL single_exec: busy=%b rsp_valid=%b req_ready=%b want 1 0 0000", busy, rsp_valid, req_ready); end
      checks++; if (cpu_a !== 8'd10 || cpu_b !== 8'd20) begin errors++; $display("FAIL single_operands: got %0d,%0d want 10,20", cpu_a, cpu_b); end
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'd30) begin errors++; $display("FAIL single_rsp: valid=%b id=%0d data=%0d want 1 0 30", rsp_valid, rsp_id, rsp_data); end
      rsp_ready = 1'b1;
      tick;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin;
      int exp;
      reset = 1'b1; tick; reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(i*10 + 5);
         req_b[i*8 +: 8] = 8'(i + 1);
         req_op[i] = 1'b0;
      end
      req_valid = 4'hF; rsp_ready = 1'b1; #1;
      for (int g = 0; g < 5; g++) begin
         exp = g % 4;
         for (int c = 0; c < 10 && req_ready === 4'h0; c++) tick;
         checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, 4'(1 << exp)); end
         tick;
         for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) tick;
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_data !== 8'(exp*11 + 6)) begin errors++; $display("FAIL rr_rsp%0d: valid=%b id=%0d data=%0d want 1 %0d %0d", g, rsp_valid, rsp_id, rsp_data, exp, exp*11 + 6); end
         tick;
      end
      req_valid = 4'h0; rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      req_a[23:16] = 8'd200; req_b[23:16] = 8'd100; req_op[2] = 1'b0;
      req_valid = 4'b0100; #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
      tick;
      req_valid = 4'b1011;
      tick;
      for (int k = 0; k < 5; k++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'd44 || req_ready !== 4'h0) begin errors++; $display("FAIL bp_hold%0d: valid=%b id=%0d data=%0d ready=%b want 1 2 44 0000", k, rsp_valid, rsp_id, rsp_data, req_ready); end
         tick;
      end
      rsp_ready = 1'b1; req_valid = 4'h0; #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hs_cycle: rsp_valid=%b want 1", rsp_valid); end
      tick;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_wrap;
      req_valid = 4'b1000; #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b want 1000", req_ready); end
      tick;
      req_valid = 4'b1001;
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL wrap_rsp3: valid=%b id=%0d want 1 3", rsp_valid, rsp_id); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b want 0001", req_ready); end
      tick;
      req_valid = 4'h0;
      tick;
      rsp_ready = 1'b1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL wrap_rsp0: valid=%b id=%0d want 1 0", rsp_valid, rsp_id); end
      tick;
      rsp_ready = 1'b0;
      req_valid = 4'b0101; #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_skip: got %b want 0100", req_ready); end
      req_valid = 4'b0001; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_search: got %b want 0001", req_ready); end
      req_valid = 4'h0;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_no_grant: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_abort;
      req_valid = 4'b0001; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_grant: got %b want 0001", req_ready); end
      tick;
      req_valid = 4'h0;
      reset = 1'b1; tick; reset = 1'b0;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_exec: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
      req_valid = 4'b0100;
      tick;
      req_valid = 4'h0;
      tick;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL abort_reach_resp: rsp_valid=%b want 1", rsp_valid); end
      reset = 1'b1; tick; reset = 1'b0;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_resp: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
      tick; tick;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: rsp_valid=%b want 0", rsp_valid); end
      req_valid = 4'b0110; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL abort_ptr: got %b want 0010", req_ready); end
      tick;
      req_valid = 4'h0;
      for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'd17) begin errors++; $display("FAIL abort_next_rsp: valid=%b id=%0d data=%0d want 1 1 17", rsp_valid, rsp_id, rsp_data); end
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
   endtask

   task automatic test_cpu_lat3;
      reset = 1'b1; tick; reset = 1'b0;
      req_a[15:8] = 8'd7; req_b[15:8] = 8'd9; req_op[1] = 1'b1;
      req_valid = 4'b0010; #1;
      checks++; if (req_ready3 !== 4'b0010) begin errors++; $display("FAIL lat3_grant: got %b want 0010", req_ready3); end
      tick;
      req_valid = 4'h0;
      for (int k = 1; k <= 3; k++) begin
         checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b1) begin errors++; $display("FAIL lat3_exec%0d: valid=%b busy=%b want 0 1", k, rsp_valid3, busy3); end
         tick;
      end
      checks++; if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd1 || rsp_data3 !== 8'd254 || cpu_op3 !== 1'b1) begin errors++; $display("FAIL lat3_rsp: valid=%b id=%0d data=%0d op=%b want 1 1 254 1", rsp_valid3, rsp_id3, rsp_data3, cpu_op3); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      checks++; if (busy3 !== 1'b0 || rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_idle: busy=%b valid=%b want 0 0", busy3, rsp_valid3); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      test_reset;
      test_single;
      test_round_robin;
      test_backpressure;
      test_wrap;
      test_reset_abort;
      test_cpu_lat3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
